// File: rtl/tabajara_pkg.sv
// Shared constants and slot-state encoding for the enemy-shot engine.
package tabajara_pkg;
    localparam int N_ENEMY  = 25;
    localparam int COLS     = 5;
    localparam int ESP_X    = 16;
    localparam int ESP_Y    = 12;
    localparam int Y_LIMITE = 239;
    localparam int JOG_Y    = 220;
    localparam int JOG_W    = 16;
    localparam int JOG_H    = 8;

    typedef enum logic {
        LIVRE = 1'b0,
        ATIVO = 1'b1
    } slot_state_t;
endpackage

// File: rtl/enemy_shot_slot.sv
// One bullet slot: LIVRE/ATIVO state, position register, downward motion and player-hit test.
module enemy_shot_slot #(
    parameter int PASSO    = 2,
    parameter int Y_LIMITE = tabajara_pkg::Y_LIMITE,
    parameter int JOG_Y    = tabajara_pkg::JOG_Y,
    parameter int JOG_W    = tabajara_pkg::JOG_W,
    parameter int JOG_H    = tabajara_pkg::JOG_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_x,
    input  logic [7:0] load_y,
    input  logic [7:0] jog_x,
    output logic       ativo,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y,
    output logic       hit
);
    import tabajara_pkg::slot_state_t;
    import tabajara_pkg::LIVRE;
    import tabajara_pkg::ATIVO;

    slot_state_t r_state;
    slot_state_t w_state_nxt;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [7:0]  w_x_nxt;
    logic [7:0]  w_y_nxt;
    logic [8:0]  w_y_step;
    logic [8:0]  w_jog_x_end;
    logic        w_hit;

    assign w_y_step    = {1'b0, r_y} + 9'(PASSO);
    assign w_jog_x_end = {1'b0, jog_x} + 9'(JOG_W);

    // Hit looks only at registered position so it is stable for the whole cycle.
    assign w_hit = (r_state == ATIVO)
                && ({1'b0, r_x} >= {1'b0, jog_x}) && ({1'b0, r_x} < w_jog_x_end)
                && ({1'b0, r_y} >= 9'(JOG_Y)) && ({1'b0, r_y} < 9'(JOG_Y + JOG_H));

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            LIVRE: begin
                if (load) begin
                    w_state_nxt = ATIVO;
                    w_x_nxt     = load_x;
                    w_y_nxt     = load_y;
                end
            end
            ATIVO: begin
                if (w_hit) begin
                    w_state_nxt = LIVRE;
                end else if (tick) begin
                    if (w_y_step > 9'(Y_LIMITE)) begin
                        w_state_nxt = LIVRE;
                    end else begin
                        w_y_nxt = w_y_step[7:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LIVRE;
            r_x     <= 8'd0;
            r_y     <= 8'd0;
        end else if (restart) begin
            r_state <= LIVRE;
            r_x     <= 8'd0;
            r_y     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

    assign ativo = (r_state == ATIVO);
    assign pos_x = r_x;
    assign pos_y = r_y;
    assign hit   = w_hit;
endmodule

// File: rtl/enemy_shot_pool.sv
// Enemy bullet pool: picks the lowest valid shooter, places it in the lowest free slot,
// and drives the shared movement tick plus the hit / drop pulses.
module enemy_shot_pool #(
    parameter int N_ENEMY    = tabajara_pkg::N_ENEMY,
    parameter int N_TIROS    = 4,
    parameter int COLS       = tabajara_pkg::COLS,
    parameter int ESP_X      = tabajara_pkg::ESP_X,
    parameter int ESP_Y      = tabajara_pkg::ESP_Y,
    parameter int ATRASO_MOV = 50000,
    parameter int PASSO      = 2,
    parameter int Y_LIMITE   = tabajara_pkg::Y_LIMITE,
    parameter int JOG_Y      = tabajara_pkg::JOG_Y,
    parameter int JOG_W      = tabajara_pkg::JOG_W,
    parameter int JOG_H      = tabajara_pkg::JOG_H
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [N_ENEMY-1:0]   ID_enemy_tiro,
    input  logic [N_ENEMY-1:0]   enemy_vivos,
    input  logic [7:0]           bloco_pos_X,
    input  logic [7:0]           bloco_pos_Y,
    input  logic [7:0]           jogador_pos_X,
    output logic [8*N_TIROS-1:0] tiro_X,
    output logic [8*N_TIROS-1:0] tiro_Y,
    output logic [N_TIROS-1:0]   tiro_ativo,
    output logic                 jogador_atingido,
    output logic                 tiro_descartado
);
    localparam int CNT_W = (ATRASO_MOV > 1) ? $clog2(ATRASO_MOV) : 1;

    logic [CNT_W-1:0]   r_cnt;
    logic               w_tick;
    logic [N_ENEMY-1:0] w_valid;
    logic               w_req;
    logic [9:0]         w_sx;
    logic [9:0]         w_sy;
    logic               w_in_range;
    logic               w_any_free;
    logic [N_TIROS-1:0] w_free_1h;
    logic               w_spawn;
    logic               w_drop;
    logic [N_TIROS-1:0] w_load;
    logic [N_TIROS-1:0] w_hit;

    assign w_valid = ID_enemy_tiro & enemy_vivos;
    assign w_tick  = (r_cnt == CNT_W'(ATRASO_MOV - 1));

    // Descending scan: the last match written is the lowest index, which wins.
    always_comb begin
        w_req = 1'b0;
        w_sx  = 10'd0;
        w_sy  = 10'd0;
        for (int k = N_ENEMY - 1; k >= 0; k--) begin
            if (w_valid[k]) begin
                w_req = 1'b1;
                w_sx  = 10'(bloco_pos_X) + 10'((k % COLS) * ESP_X + ESP_X / 2);
                w_sy  = 10'(bloco_pos_Y) + 10'((k / COLS) * ESP_Y + ESP_Y);
            end
        end
    end

    always_comb begin
        w_any_free = 1'b0;
        w_free_1h  = '0;
        for (int i = N_TIROS - 1; i >= 0; i--) begin
            if (!tiro_ativo[i]) begin
                w_any_free = 1'b1;
                w_free_1h  = N_TIROS'(1) << i;
            end
        end
    end

    // Spawn coordinates are checked wide so an off-screen shot is dropped, never wrapped.
    assign w_in_range = (w_sx <= 10'd255) && (w_sy <= 10'd255) && (w_sy <= 10'(Y_LIMITE));
    assign w_spawn    = w_req && w_in_range && w_any_free;
    assign w_drop     = w_req && !w_spawn;
    assign w_load     = w_spawn ? w_free_1h : '0;

    for (genvar i = 0; i < N_TIROS; i++) begin : g_slot
        enemy_shot_slot #(
            .PASSO   (PASSO),
            .Y_LIMITE(Y_LIMITE),
            .JOG_Y   (JOG_Y),
            .JOG_W   (JOG_W),
            .JOG_H   (JOG_H)
        ) u_slot (
            .clk    (clk),
            .reset  (reset),
            .restart(restart),
            .tick   (w_tick),
            .load   (w_load[i]),
            .load_x (w_sx[7:0]),
            .load_y (w_sy[7:0]),
            .jog_x  (jogador_pos_X),
            .ativo  (tiro_ativo[i]),
            .pos_x  (tiro_X[8*i +: 8]),
            .pos_y  (tiro_Y[8*i +: 8]),
            .hit    (w_hit[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt            <= '0;
            jogador_atingido <= 1'b0;
            tiro_descartado  <= 1'b0;
        end else if (restart) begin
            r_cnt            <= '0;
            jogador_atingido <= 1'b0;
            tiro_descartado  <= 1'b0;
        end else begin
            r_cnt            <= w_tick ? '0 : r_cnt + CNT_W'(1);
            jogador_atingido <= |w_hit;
            tiro_descartado  <= w_drop;
        end
    end
endmodule

// File: tb/tb_enemy_shot_pool.sv
// Bench for enemy_shot_pool: directed vector table, reset sequence and randomized model comparison.
module tb_enemy_shot_pool;
    localparam int NE  = 25;
    localparam int NT  = 4;
    localparam int ATR = 4;
    localparam logic [24:0] ALL = 25'h1FF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [24:0] fire;
    logic [24:0] alive;
    logic [7:0]  bx;
    logic [7:0]  by;
    logic [7:0]  px;
    logic [31:0] tx;
    logic [31:0] ty;
    logic [3:0]  act;
    logic        hit;
    logic        desc;

    enemy_shot_pool #(.ATRASO_MOV(ATR)) dut (
        .clk             (clk),
        .reset           (reset),
        .restart         (restart),
        .ID_enemy_tiro   (fire),
        .enemy_vivos     (alive),
        .bloco_pos_X     (bx),
        .bloco_pos_Y     (by),
        .jogador_pos_X   (px),
        .tiro_X          (tx),
        .tiro_Y          (ty),
        .tiro_ativo      (act),
        .jogador_atingido(hit),
        .tiro_descartado (desc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit m_act[NT];
    int m_x[NT];
    int m_y[NT];
    int m_cnt;
    bit m_hit;
    bit m_desc;

    typedef struct {
        bit          rs;
        logic [24:0] f;
        logic [24:0] a;
        int          bx, by, px;
        int          e_act, e_x0, e_y0, e_desc, e_hit;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [24:0] en(input int k);
        return 25'(1) << k;
    endfunction

    function automatic vec_t mk(input bit rs, input logic [24:0] f, input logic [24:0] a,
                                input int b_x, input int b_y, input int p_x,
                                input int e_act, input int e_x0, input int e_y0,
                                input int e_desc, input int e_hit);
        vec_t v;
        v.rs = rs; v.f = f; v.a = a; v.bx = b_x; v.by = b_y; v.px = p_x;
        v.e_act = e_act; v.e_x0 = e_x0; v.e_y0 = e_y0; v.e_desc = e_desc; v.e_hit = e_hit;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NT; i++) begin
            m_act[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cnt = 0; m_hit = 1'b0; m_desc = 1'b0;
    endfunction

    // Reference: one clock edge of the pool, from the behavioural rules.
    function automatic void model_step();
        bit was_free[NT];
        bit tick;
        bit h;
        int k, s, sx, sy, ipx;
        if (restart) begin
            model_clear();
            return;
        end
        ipx  = int'(px);
        tick = (m_cnt == ATR - 1);
        m_cnt = (m_cnt + 1) % ATR;
        h = 1'b0;
        for (int i = 0; i < NT; i++) begin
            was_free[i] = !m_act[i];
            if (m_act[i]) begin
                if (m_x[i] >= ipx && m_x[i] < ipx + 16 && m_y[i] >= 220 && m_y[i] < 228) begin
                    m_act[i] = 1'b0;
                    h = 1'b1;
                end else if (tick) begin
                    if (m_y[i] + 2 > 239) m_act[i] = 1'b0;
                    else m_y[i] = m_y[i] + 2;
                end
            end
        end
        m_hit  = h;
        m_desc = 1'b0;
        k = -1;
        for (int j = NE - 1; j >= 0; j--) if (fire[j] && alive[j]) k = j;
        if (k >= 0) begin
            sx = int'(bx) + (k % 5) * 16 + 8;
            sy = int'(by) + (k / 5) * 12 + 12;
            s = -1;
            for (int i = NT - 1; i >= 0; i--) if (was_free[i]) s = i;
            if (sx > 255 || sy > 239 || s < 0) begin
                m_desc = 1'b1;
            end else begin
                m_act[s] = 1'b1; m_x[s] = sx; m_y[s] = sy;
            end
        end
    endfunction

    task automatic cmp_model();
        int ea;
        ea = 0;
        for (int i = 0; i < NT; i++) if (m_act[i]) ea |= (1 << i);
        chk("rnd_ativo", int'(act), ea);
        chk("rnd_hit", int'(hit), int'(m_hit));
        chk("rnd_desc", int'(desc), int'(m_desc));
        for (int i = 0; i < NT; i++) begin
            if (m_act[i]) begin
                chk("rnd_x", int'(tx[8*i +: 8]), m_x[i]);
                chk("rnd_y", int'(ty[8*i +: 8]), m_y[i]);
            end
        end
    endtask

    task automatic cyc(input bit rs, input logic [24:0] f, input logic [24:0] a,
                       input int b_x, input int b_y, input int p_x);
        @(negedge clk);
        restart = rs; fire = f; alive = a;
        bx = 8'(b_x); by = 8'(b_y); px = 8'(p_x);
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [24:0] rf, ra;
        int rbx, rby, rpx;
        bit rrs;

        reset = 1'b1; restart = 1'b0; fire = '0; alive = '0;
        bx = '0; by = '0; px = '0;
        model_clear();
        #12;
        chk("reset_ativo", int'(act), 0);
        chk("reset_x", int'(tx), 0);
        chk("reset_y", int'(ty), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_desc", int'(desc), 0);
        reset = 1'b0;

        // rs, fire, alive, bx, by, px -> ativo, x0, y0 (-1 = not checked), desc, hit
        tbl.push_back(mk(1, '0, ALL, 10, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, en(7), ALL, 10, 20, 0, 1, 50, 44, 0, 0));
        tbl.push_back(mk(1, '0, ALL, 10, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, en(3) | en(7), ALL & ~en(3), 10, 20, 0, 1, 50, 44, 0, 0));
        tbl.push_back(mk(1, '0, ALL, 10, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 20, 0, 1, 18, 32, 0, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 20, 0, 3, 18, 32, 0, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 20, 0, 7, 18, 32, 0, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 20, 0, 15, 18, 34, 0, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 20, 0, 15, 18, 34, 1, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 20, 0, 15, 18, 34, 0, 0));
        tbl.push_back(mk(1, '0, ALL, 10, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 230, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 227, 0, 1, 18, 239, 0, 0));
        tbl.push_back(mk(0, en(4), ALL, 250, 0, 0, 1, 18, 239, 1, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 20, 0, 0, 18, -1, 0, 0));
        tbl.push_back(mk(1, '0, ALL, 10, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, en(0), ALL, 10, 226, 0, 1, 18, 238, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 226, 0, 1, 18, 238, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 226, 0, 1, 18, 238, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 226, 0, 0, 18, -1, 0, 0));
        tbl.push_back(mk(1, '0, ALL, 10, 194, 40, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, en(7), ALL, 10, 194, 40, 1, 50, 218, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 194, 40, 1, 50, 218, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 194, 40, 1, 50, 218, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 194, 40, 1, 50, 220, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 10, 194, 40, 0, 50, 220, 0, 1));
        tbl.push_back(mk(0, '0, ALL, 10, 194, 40, 0, 50, 220, 0, 0));
        tbl.push_back(mk(1, '0, ALL, 16, 194, 40, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, en(7), ALL, 16, 194, 40, 1, 56, 218, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 16, 194, 40, 1, 56, 218, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 16, 194, 40, 1, 56, 218, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 16, 194, 40, 1, 56, 220, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 16, 194, 40, 1, 56, 220, 0, 0));
        tbl.push_back(mk(0, '0, ALL, 16, 194, 40, 1, 56, 220, 0, 0));

        foreach (tbl[n]) begin
            cyc(tbl[n].rs, tbl[n].f, tbl[n].a, tbl[n].bx, tbl[n].by, tbl[n].px);
            chk($sformatf("tbl%0d_ativo", n), int'(act), tbl[n].e_act);
            chk($sformatf("tbl%0d_x0", n), int'(tx[7:0]), tbl[n].e_x0);
            if (tbl[n].e_y0 >= 0) chk($sformatf("tbl%0d_y0", n), int'(ty[7:0]), tbl[n].e_y0);
            chk($sformatf("tbl%0d_desc", n), int'(desc), tbl[n].e_desc);
            chk($sformatf("tbl%0d_hit", n), int'(hit), tbl[n].e_hit);
        end

        // Asynchronous reset in flight, then the tick phase must restart from zero.
        cyc(1, '0, ALL, 10, 20, 100);
        cyc(0, en(0), ALL, 10, 20, 100);
        cyc(0, en(0), ALL, 10, 20, 100);
        cyc(0, en(0), ALL, 10, 20, 100);
        chk("pre_reset_ativo", int'(act), 7);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("async_ativo", int'(act), 0);
        chk("async_x", int'(tx), 0);
        chk("async_y", int'(ty), 0);
        reset = 1'b0;
        cyc(0, en(0), ALL, 10, 20, 100);
        chk("post_spawn_ativo", int'(act), 1);
        chk("post_spawn_y", int'(ty[7:0]), 32);
        cyc(0, '0, ALL, 10, 20, 100);
        cyc(0, '0, ALL, 10, 20, 100);
        chk("post_no_tick_y", int'(ty[7:0]), 32);
        cyc(0, '0, ALL, 10, 20, 100);
        chk("post_tick_y", int'(ty[7:0]), 34);

        cyc(1, '0, ALL, 10, 20, 100);
        rpx = 40;
        for (int n = 0; n < 600; n++) begin
            rrs = ($urandom_range(79) == 0);
            rf  = ($urandom_range(2) == 0) ? 25'($urandom & $urandom & $urandom) : 25'(0);
            ra  = 25'($urandom | $urandom);
            rbx = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(0, 60));
            rby = int'($urandom_range(150, 230));
            if (n % 16 == 0) rpx = int'($urandom_range(10, 110));
            cyc(rrs, rf, ra, rbx, rby, rpx);
            cmp_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
